mux41: RTL and testbench

MUX41 -- requirements
Module: mux41

---
 rtl/mux41_pkg.sv | 18 +
 rtl/mux41_comb.sv | 15 +
 rtl/mux41.sv | 60 ++++++
 tb/tb_mux41.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mux41_pkg.sv
// Shared constants, select type and select decode for the 4:1 mux block.
package mux41_pkg;

  localparam int N_IN  = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // One-hot decode of the select; AND-OR selection built on this keeps
  // unknowns on unselected inputs from reaching the output.
  function automatic logic [N_IN-1:0] sel_onehot(input sel_t sel);
    logic [N_IN-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux41_comb.sv
// Purely combinational 4:1 single-bit selector.
module mux41_comb
  import mux41_pkg::*;
(
  input  logic [N_IN-1:0] i,
  input  sel_t            s,
  output logic            y
);

  // AND-OR select: an unselected bit is masked by a 0 before the reduction.
  always_comb begin
    y = |(i & sel_onehot(s));
  end

endmodule

// File: rtl/mux41.sv
// 4:1 mux with combinational output plus registered copy, valid and change flag.
module mux41 #(
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  i,
  input  logic [SEL_W-1:0] s,
  input  logic             en,
  output logic             y,
  output logic             y_q,
  output logic             y_vld,
  output logic             y_chg
);

  import mux41_pkg::*;

  sel_t sel;
  logic rst_sync_q, rst_sync_d;
  logic y_d, y_vld_q, y_vld_d, y_chg_q, y_chg_d;
  logic cap;

  assign sel = sel_t'(s);

  mux41_comb u_comb (
    .i (i),
    .s (sel),
    .y (y)
  );

  // Capture is only allowed once the release of reset has been seen by a
  // clock edge, so the first capture lands on the second edge after release.
  always_comb begin
    rst_sync_d = 1'b1;
    cap        = rst_sync_q & en;
    y_d        = cap ? y : y_q;
    y_vld_d    = y_vld_q | cap;
    y_chg_d    = cap & (y != y_q);
  end

  // Async-assert reset; all registered outputs clear immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 1'b0;
      y_q        <= 1'b0;
      y_vld_q    <= 1'b0;
      y_chg_q    <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
      y_q        <= y_d;
      y_vld_q    <= y_vld_d;
      y_chg_q    <= y_chg_d;
    end
  end

  assign y_vld = y_vld_q;
  assign y_chg = y_chg_q;

endmodule

// File: tb/tb_mux41.sv
// Self-checking bench for mux41: behavioural model + directed and random stimulus.
module tb_mux41;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] i;
  logic [1:0] s;
  logic       en;
  logic       y, y_q, y_vld, y_chg;

  int n_tests = 0;
  int n_fail  = 0;

  mux41 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .s     (s),
    .en    (en),
    .y     (y),
    .y_q   (y_q),
    .y_vld (y_vld),
    .y_chg (y_chg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic pick(input logic [3:0] iv, input logic [1:0] sv);
    return logic'((iv >> sv) & 4'd1);
  endfunction

  // Reference model: edges counted since reset release, value/flags from the rules.
  int   m_edges = 0;
  logic m_yq = 1'b0, m_vld = 1'b0, m_chg = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges <= 0;
      m_yq    <= 1'b0;
      m_vld   <= 1'b0;
      m_chg   <= 1'b0;
    end else begin
      m_edges <= (m_edges < 2) ? m_edges + 1 : m_edges;
      if (m_edges >= 1 && en) begin
        m_chg <= (pick(i, s) != m_yq);
        m_yq  <= pick(i, s);
        m_vld <= 1'b1;
      end else begin
        m_chg <= 1'b0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("y_vs_model",     y,     pick(i, s));
    check("y_q_vs_model",   y_q,   m_yq);
    check("y_vld_vs_model", y_vld, m_vld);
    check("y_chg_vs_model", y_chg, m_chg);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] iv;
    rst_n = 1'b0; i = 4'b0000; s = 2'b00; en = 1'b0;
    #1;
    check("rst_y",     y,     1'b0);
    check("rst_y_q",   y_q,   1'b0);
    check("rst_y_vld", y_vld, 1'b0);
    check("rst_y_chg", y_chg, 1'b0);

    tick(); tick();
    rst_n = 1'b1;
    en    = 1'b1;
    tick();                                  // synchronizing edge, no capture
    check("sync_edge_vld", y_vld, 1'b0);
    tick();                                  // first capture
    check("first_cap_y_q", y_q,   1'b0);
    check("first_cap_vld", y_vld, 1'b1);
    check("first_cap_chg", y_chg, 1'b0);
    en = 1'b0;

    // Diagonal walk, 10-unit steps
    i = 4'b0001; s = 2'b00; #1 check("diag0", y, 1'b1); #9;
    i = 4'b0010; s = 2'b01; #1 check("diag1", y, 1'b1); #9;
    i = 4'b0100; s = 2'b10; #1 check("diag2", y, 1'b1); #9;
    i = 4'b1000; s = 2'b11; #1 check("diag3", y, 1'b1); #9;

    // Off-diagonal, then full sweep
    i = 4'b0001; s = 2'b01; #1 check("offdiag_a", y, 1'b0);
    i = 4'b1110; s = 2'b00; #1 check("offdiag_b", y, 1'b0);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 4; b++) begin
        i = 4'(a); s = 2'(b);
        #1 check("sweep", y, pick(4'(a), 2'(b)));
      end
    end
    tick();

    // Load 1 then 0 on consecutive edges
    en = 1'b1; i = 4'b0100; s = 2'b10;
    tick();
    check("seqN_y_q",   y_q,   1'b1);
    check("seqN_chg",   y_chg, 1'b1);
    i = 4'b0000;
    tick();
    check("seqN1_y_q",  y_q,   1'b0);
    check("seqN1_chg",  y_chg, 1'b1);
    tick();
    check("seqN2_chg",  y_chg, 1'b0);

    // Hold with en=0 while i toggles
    i = 4'b1111;
    tick();
    en = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      i = 4'($urandom_range(0, 15));
      #1 check("hold_y", y, pick(i, s));
      tick();
      check("hold_y_q", y_q,   1'b1);
      check("hold_vld", y_vld, 1'b1);
      check("hold_chg", y_chg, 1'b0);
    end

    // Mid-cycle async reset with y_q=1
    #1 rst_n = 1'b0;
    #1;
    check("arst_y_q", y_q,   1'b0);
    check("arst_vld", y_vld, 1'b0);
    check("arst_chg", y_chg, 1'b0);
    check("arst_y",   y,     pick(i, s));
    tick();
    rst_n = 1'b1; en = 1'b1; i = 4'b1111;
    tick();
    check("rel_sync_vld", y_vld, 1'b0);
    tick();
    check("rel_cap_vld",  y_vld, 1'b1);
    check("rel_cap_y_q",  y_q,   1'b1);
    check("rel_cap_chg",  y_chg, 1'b1);

    // Randomised traffic with occasional reset pulses
    for (int k = 0; k < 400; k++) begin
      iv = 4'($urandom_range(0, 15));
      i  = iv;
      s  = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        #1 rst_n = 1'b0;
        #1 check("rand_arst_y_q", y_q, 1'b0);
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
